// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM arbiter: requester IDs, response tag, defaults.
// Optional feature macro used by rom_arbiter: ROM_ARB_STATS_EN (grant/conflict counters).
package rom_arb_pkg;

  localparam int unsigned WORDS_DEF    = 4096;
  localparam int unsigned ROM_LAT_DEF  = 1;
  localparam int unsigned MAX_WAIT_DEF = 4;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WIDX_W = 30;
  localparam int unsigned STAT_W = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Travels down the response pipe alongside the ROM read.
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } resp_tag_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Bus bundle between fetch/LSU requesters, the ROM array and the arbiter.
// master: requester + ROM side (drives valids, addresses, rom_rdata).
// slave : arbiter side (drives readys, responses, rom_en/rom_addr).
interface rom_arbiter_if;
  import rom_arb_pkg::*;

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_valid;
  logic              d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              rom_en;
  logic [WIDX_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;

  modport master (
    output if_valid, if_addr, d_valid, d_addr, rom_rdata,
    input  if_ready, if_rvalid, if_rdata, if_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  rom_en, rom_addr
  );

  modport slave (
    input  if_valid, if_addr, d_valid, d_addr, rom_rdata,
    output if_ready, if_rvalid, if_rdata, if_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output rom_en, rom_addr
  );

endinterface

// File: rtl/rom_arb_resp_pipe.sv
// ROM_LAT-deep shift register carrying response tags in lockstep with the ROM read.
// Ports: clk, rst_n (async active-low), tag_in (tag of this cycle's grant),
//        tag_out (tag whose ROM data is on rom_rdata this cycle).
module rom_arb_resp_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  resp_tag_t tag_q [ROM_LAT];

  // Reset clears every stage so in-flight responses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[ROM_LAT-1];

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates one synchronous-read ROM port between instruction fetch and data load.
// Ports: clk, rst_n (async active-low), bus (rom_arbiter_if.slave: fetch/data
//        request+response channels and ROM read port).
// Optional: define ROM_ARB_STATS_EN to add stat_if_grants, stat_d_grants and
//           stat_conflicts (32-bit wrapping counters).
// Ready, rom_en/rom_addr and response data are combinational by design: the
// grant must reach the ROM in the request cycle and rom_rdata is forwarded as-is.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned WORDS    = WORDS_DEF,
  parameter int unsigned ROM_LAT  = ROM_LAT_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_arbiter_if.slave      bus
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_if_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;
  logic              gnt_if_c;
  logic              gnt_d_c;
  logic              any_gnt_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic              addr_err_c;
  resp_tag_t         tag_in_c;
  resp_tag_t         tag_out;

  // Grant select: data wins conflicts unless fetch has starved MAX_WAIT cycles.
  always_comb begin
    gnt_if_c = 1'b0;
    gnt_d_c  = 1'b0;
    if (rst_n) begin
      if (bus.if_valid && bus.d_valid) begin
        if (starve_q == CNT_W'(MAX_WAIT)) gnt_if_c = 1'b1;
        else                              gnt_d_c  = 1'b1;
      end else begin
        gnt_if_c = bus.if_valid;
        gnt_d_c  = bus.d_valid;
      end
    end
  end

  assign any_gnt_c  = gnt_if_c | gnt_d_c;
  assign sel_addr_c = gnt_if_c ? bus.if_addr : bus.d_addr;
  assign addr_err_c = (sel_addr_c[1:0] != 2'b00) ||
                      ({2'b00, sel_addr_c[31:2]} >= 32'(WORDS));

  assign bus.if_ready = gnt_if_c;
  assign bus.d_ready  = gnt_d_c;
  assign bus.rom_en   = any_gnt_c & ~addr_err_c;
  assign bus.rom_addr = bus.rom_en ? sel_addr_c[31:2] : '0;

  // Errored grants still occupy a pipe slot so latency and ordering are uniform.
  always_comb begin
    tag_in_c       = '0;
    tag_in_c.valid = any_gnt_c;
    tag_in_c.id    = gnt_d_c ? REQ_D : REQ_IF;
    tag_in_c.err   = any_gnt_c & addr_err_c;
  end

  // Starvation counter: counts consecutive lost cycles of a pending fetch.
  always_comb begin
    starve_d = '0;
    if (bus.if_valid && !gnt_if_c) begin
      starve_d = (starve_q == CNT_W'(MAX_WAIT)) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  rom_arb_resp_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_resp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in_c),
    .tag_out (tag_out)
  );

  // Response steering; error responses and the idle port return zero data.
  assign bus.if_rvalid = tag_out.valid & (tag_out.id == REQ_IF);
  assign bus.d_rvalid  = tag_out.valid & (tag_out.id == REQ_D);
  assign bus.if_err    = bus.if_rvalid & tag_out.err;
  assign bus.d_err     = bus.d_rvalid & tag_out.err;
  assign bus.if_rdata  = (bus.if_rvalid && !tag_out.err) ? bus.rom_rdata : '0;
  assign bus.d_rdata   = (bus.d_rvalid && !tag_out.err) ? bus.rom_rdata : '0;

`ifdef ROM_ARB_STATS_EN
  // Usage counters, wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (gnt_if_c)                   stat_if_grants <= stat_if_grants + STAT_W'(1);
      if (gnt_d_c)                    stat_d_grants  <= stat_d_grants + STAT_W'(1);
      if (bus.if_valid && bus.d_valid) stat_conflicts <= stat_conflicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed steps followed by random traffic,
// checked cycle by cycle against a transaction-level model (grant rule, expected
// response queue with due cycles, ROM contents function).
module tb_rom_arbiter;

  localparam int unsigned TB_WORDS = 4096;
  localparam int unsigned TB_LAT   = 2;
  localparam int unsigned TB_MAX   = 4;

  logic clk;
  logic rst_n;

  rom_arbiter_if bus ();

`ifdef ROM_ARB_STATS_EN
  logic [31:0] stat_if_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_conflicts;
`endif

  rom_arbiter #(
    .WORDS    (TB_WORDS),
    .ROM_LAT  (TB_LAT),
    .MAX_WAIT (TB_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef ROM_ARB_STATS_EN
    ,
    .stat_if_grants (stat_if_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 4 is fixed, others derived from the index.
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    if (idx == 30'd4) return 32'hDEAD_BEEF;
    return ({2'b00, idx} * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // Synchronous-read ROM with TB_LAT cycles of latency; junk when not enabled.
  logic [31:0] rom_pipe [TB_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_en ? rom_word(bus.rom_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < int'(TB_LAT); i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_rdata = rom_pipe[TB_LAT-1];

  typedef struct {
    int          due;
    logic        port;   // 0 = fetch, 1 = data
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   m_starve;
  int   m_conf, m_ig, m_dg;
  int   checks, failures;
  logic gi, gd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= TB_WORDS * 4);
  endfunction

  // One clock of stimulus; compares every output against the model.
  task automatic cycle(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da,
                       output logic og, output logic odg);
    logic        egi, egd, eerr;
    logic [31:0] ea;
    exp_t        e;
    logic        rv_if, rv_d, er_if, er_d;
    logic [31:0] rd_if, rd_d;
    bus.if_valid = iv;
    bus.if_addr  = ia;
    bus.d_valid  = dv;
    bus.d_addr   = da;
    @(negedge clk);
    if (iv && dv) begin
      egi = (m_starve == int'(TB_MAX));
      egd = !egi;
    end else begin
      egi = iv;
      egd = dv;
    end
    ea   = egi ? ia : da;
    eerr = addr_bad(ea);
    chk("if_ready", 32'(bus.if_ready), 32'(egi));
    chk("d_ready", 32'(bus.d_ready), 32'(egd));
    chk("rom_en", 32'(bus.rom_en), 32'((egi || egd) && !eerr));
    if ((egi || egd) && !eerr) chk("rom_addr", {2'b00, bus.rom_addr}, ea / 4);

    rv_if = 1'b0; rv_d = 1'b0; er_if = 1'b0; er_d = 1'b0; rd_if = '0; rd_d = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.port) begin rv_d = 1'b1;  er_d = e.err;  rd_d = e.data;  end
      else        begin rv_if = 1'b1; er_if = e.err; rd_if = e.data; end
    end
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(rv_if));
    chk("if_err", 32'(bus.if_err), 32'(er_if));
    chk("if_rdata", bus.if_rdata, rd_if);
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(rv_d));
    chk("d_err", 32'(bus.d_err), 32'(er_d));
    chk("d_rdata", bus.d_rdata, rd_d);

    if (egi || egd) begin
      e.due  = cyc + int'(TB_LAT);
      e.port = egd;
      e.err  = eerr;
      e.data = eerr ? 32'h0 : rom_word(ea[31:2]);
      q.push_back(e);
    end
    m_starve = (iv && !egi) ? ((m_starve < int'(TB_MAX)) ? m_starve + 1 : m_starve) : 0;
    if (iv && dv) m_conf++;
    if (egi) m_ig++;
    if (egd) m_dg++;
    og  = egi;
    odg = egd;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "/if_ready"}, 32'(bus.if_ready), 32'h0);
    chk({ph, "/d_ready"}, 32'(bus.d_ready), 32'h0);
    chk({ph, "/rom_en"}, 32'(bus.rom_en), 32'h0);
    chk({ph, "/rom_addr"}, {2'b00, bus.rom_addr}, 32'h0);
    chk({ph, "/if_rvalid"}, 32'(bus.if_rvalid), 32'h0);
    chk({ph, "/if_rdata"}, bus.if_rdata, 32'h0);
    chk({ph, "/if_err"}, 32'(bus.if_err), 32'h0);
    chk({ph, "/d_rvalid"}, 32'(bus.d_rvalid), 32'h0);
    chk({ph, "/d_rdata"}, bus.d_rdata, 32'h0);
    chk({ph, "/d_err"}, 32'(bus.d_err), 32'h0);
`ifdef ROM_ARB_STATS_EN
    chk({ph, "/stat_if"}, stat_if_grants, 32'h0);
    chk({ph, "/stat_d"}, stat_d_grants, 32'h0);
    chk({ph, "/stat_conf"}, stat_conflicts, 32'h0);
`endif
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, TB_WORDS - 1)) << 2;
    if (r == 0)      a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'(TB_WORDS * 4) + (32'($urandom_range(0, 1000)) << 2);
    else if (r == 2) a = $urandom;
    return a;
  endfunction

  logic        p_iv, p_dv;
  logic [31:0] p_ia, p_da;

  initial begin
    checks = 0; failures = 0; cyc = 0; m_starve = 0;
    m_conf = 0; m_ig = 0; m_dg = 0;
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.d_valid  = 1'b0; bus.d_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Lone fetch of word 4.
    cycle(1'b1, 32'h10, 1'b0, 32'h0, gi, gd);
    chk("fetch_lone_grant", 32'(gi), 32'h1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Held fetch against continuous data: fetch must win on the 5th cycle.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h0, 1'b1, 32'h20, gi, gd);
      chk("starve_fetch_win", 32'(gi), (i == 4) ? 32'h1 : 32'h0);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Misaligned, then out-of-range data reads.
    cycle(1'b0, 32'h0, 1'b1, 32'h4002, gi, gd);
    cycle(1'b0, 32'h0, 1'b1, 32'h4000, gi, gd);
    cycle(1'b0, 32'h0, 1'b1, 32'h3FFC, gi, gd);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Alternating single-cycle requests, one grant per cycle.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle(1'b1, 32'(i * 8), 1'b0, 32'h0, gi, gd);
      else            cycle(1'b0, 32'h0, 1'b1, 32'(i * 12 + 4), gi, gd);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Reset with a fetch response in flight.
    cycle(1'b1, 32'h8, 1'b0, 32'h0, gi, gd);
    bus.if_valid = 1'b1; bus.d_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    m_starve = 0; m_conf = 0; m_ig = 0; m_dg = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("midrst_hold");
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.if_valid = 1'b0; bus.d_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Ten conflict cycles.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h4, 1'b1, 32'h24, gi, gd);
`ifdef ROM_ARB_STATS_EN
    chk("stat_conflicts10", stat_conflicts, 32'(m_conf));
    chk("stat_grants_sum10", stat_if_grants + stat_d_grants, 32'(m_ig + m_dg));
`endif
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);

    // Random traffic, requests held until accepted.
    p_iv = 1'b0; p_dv = 1'b0; p_ia = '0; p_da = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_iv) begin p_iv = ($urandom_range(0, 99) < 60); p_ia = rand_addr(); end
      if (!p_dv) begin p_dv = ($urandom_range(0, 99) < 55); p_da = rand_addr(); end
      cycle(p_iv, p_ia, p_dv, p_da, gi, gd);
      if (gi) p_iv = 1'b0;
      if (gd) p_dv = 1'b0;
    end
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 32'h0, gi, gd);
    chk("queue_drained", 32'(q.size()), 32'h0);
`ifdef ROM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 32'(m_conf));
    chk("stat_if_grants", stat_if_grants, 32'(m_ig));
    chk("stat_d_grants", stat_d_grants, 32'(m_dg));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
